// File: rtl/serial_capture_reg_16bits_pkg.sv
// Shared framing-FSM encoding, word width and clock/2 reference patterns
// for the serial capture register.
package serial_capture_reg_16bits_pkg;

  localparam int WIDTH = 16;

  localparam logic [WIDTH-1:0] ALT_WORD_A = 16'hAAAA;
  localparam logic [WIDTH-1:0] ALT_WORD_5 = 16'h5555;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_capture_reg_16bits_transition_counter.sv
// Purely combinational count of adjacent-bit transitions in a 16-bit word
// (0..15, so 5 bits never wrap).
module transition_counter_16bits
  import serial_capture_reg_16bits_pkg::*;
(
  input  logic [WIDTH-1:0] word,
  output logic [4:0]       count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      count = count + 5'(word[i] ^ word[i+1]);
    end
  end

endmodule

// File: rtl/serial_capture_reg_16bits.sv
// MSB-first serial-to-parallel capture with sync-based word framing; the
// completed word, its transition count and clock/2 flag appear one cycle after bit 16.
module serial_capture_reg_16bits #(
  parameter int WIDTH = serial_capture_reg_16bits_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             shift_in,
  input  logic             shift_en,
  input  logic             sync,
  output logic [WIDTH-1:0] parallel_out,
  output logic             word_valid,
  output logic [3:0]       bit_count,
  output logic [4:0]       toggle_count,
  output logic             alt_detect
);

  import serial_capture_reg_16bits_pkg::*;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_reg_nxt;
  logic [WIDTH-1:0] shifted;
  logic [3:0]       count_nxt;
  logic             load_word;
  logic [4:0]       toggles;

  assign shifted = (shift_reg << 1) | WIDTH'(shift_in);

  transition_counter_16bits u_transition_counter (
    .word  (shifted),
    .count (toggles)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // sync always wins, including over a 16th bit arriving in the same cycle
  always_comb begin
    state_nxt     = state;
    shift_reg_nxt = shift_reg;
    count_nxt     = bit_count;
    load_word     = 1'b0;
    if (sync) begin
      state_nxt = COLLECT;
      if (shift_en) begin
        shift_reg_nxt = WIDTH'(shift_in);
        count_nxt     = 4'd1;
      end else begin
        shift_reg_nxt = '0;
        count_nxt     = 4'd0;
      end
    end else if (state == COLLECT && shift_en) begin
      shift_reg_nxt = shifted;
      if (bit_count == 4'd15) begin
        count_nxt = 4'd0;
        load_word = 1'b1;
      end else begin
        count_nxt = bit_count + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shift_reg    <= '0;
      bit_count    <= '0;
      word_valid   <= 1'b0;
      parallel_out <= '0;
      toggle_count <= '0;
      alt_detect   <= 1'b0;
    end else begin
      shift_reg  <= shift_reg_nxt;
      bit_count  <= count_nxt;
      word_valid <= load_word;
      if (load_word) begin
        parallel_out <= shifted;
        toggle_count <= toggles;
        alt_detect   <= (shifted == ALT_WORD_A) || (shifted == ALT_WORD_5);
      end
    end
  end

endmodule

// File: tb/tb_serial_capture_reg_16bits.sv
// Randomized and directed bench for serial_capture_reg_16bits against a
// queue-based reference model of the framing rules.
module tb_serial_capture_reg_16bits;

  logic        clock;
  logic        reset_n;
  logic        shift_in;
  logic        shift_en;
  logic        sync;
  logic [15:0] parallel_out;
  logic        word_valid;
  logic [3:0]  bit_count;
  logic [4:0]  toggle_count;
  logic        alt_detect;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: frame active flag, bits of the partial word in arrival order
  bit          m_act;
  bit          q[$];
  logic [15:0] m_out;
  logic [4:0]  m_tc;
  logic        m_alt;
  logic        m_vld;

  serial_capture_reg_16bits #(.WIDTH(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .shift_in     (shift_in),
    .shift_en     (shift_en),
    .sync         (sync),
    .parallel_out (parallel_out),
    .word_valid   (word_valid),
    .bit_count    (bit_count),
    .toggle_count (toggle_count),
    .alt_detect   (alt_detect)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_step();
    logic [15:0] w;
    int t;
    if (!reset_n) begin
      m_act = 0; q.delete(); m_out = '0; m_tc = '0; m_alt = 0; m_vld = 0;
    end else begin
      m_vld = 0;
      if (sync) begin
        m_act = 1;
        q.delete();
        if (shift_en) q.push_back(shift_in);
      end else if (m_act && shift_en) begin
        q.push_back(shift_in);
        if (q.size() == 16) begin
          w = '0; t = 0;
          for (int i = 0; i < 16; i++) begin
            w = w * 2 + 16'(q[i]);
            if (i < 15 && q[i] != q[i+1]) t++;
          end
          m_out = w; m_tc = 5'(t);
          m_alt = (w == 16'hAAAA) || (w == 16'h5555);
          m_vld = 1;
          q.delete();
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic d, input logic s);
    reset_n = r; shift_en = e; shift_in = d; sync = s;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    step(1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (parallel_out !== 16'h0000) begin n_fail++; $display("FAIL reset_parallel_out: got %h want 0000", parallel_out); end
    n_cmp++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid: got %b want 0", word_valid); end
    n_cmp++; if (bit_count !== 4'd0) begin n_fail++; $display("FAIL reset_bit_count: got %0d want 0", bit_count); end
    n_cmp++; if (toggle_count !== 5'd0) begin n_fail++; $display("FAIL reset_toggle_count: got %0d want 0", toggle_count); end
    n_cmp++; if (alt_detect !== 1'b0) begin n_fail++; $display("FAIL reset_alt_detect: got %b want 0", alt_detect); end
    // IDLE must ignore shift_en without sync
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'($urandom), 1'b0);
    n_cmp++; if (bit_count !== 4'd0 || word_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ignores_bits: got cnt=%0d vld=%b want 0/0", bit_count, word_valid); end
  endtask

  task automatic test_alternating();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, ~i[0], i == 0);
      if (i < 15) begin
        n_cmp++; if (word_valid !== 1'b0 || bit_count !== 4'(i + 1)) begin n_fail++; $display("FAIL alt_progress: bit %0d got vld=%b cnt=%0d want 0/%0d", i, word_valid, bit_count, i + 1); end
      end
    end
    n_cmp++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL alt_word_valid: got %b want 1", word_valid); end
    n_cmp++; if (parallel_out !== 16'hAAAA) begin n_fail++; $display("FAIL alt_parallel_out: got %h want aaaa", parallel_out); end
    n_cmp++; if (toggle_count !== 5'd15) begin n_fail++; $display("FAIL alt_toggle_count: got %0d want 15", toggle_count); end
    n_cmp++; if (alt_detect !== 1'b1) begin n_fail++; $display("FAIL alt_detect: got %b want 1", alt_detect); end
    n_cmp++; if (bit_count !== 4'd0) begin n_fail++; $display("FAIL alt_bit_count: got %0d want 0", bit_count); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (word_valid !== 1'b0 || parallel_out !== 16'hAAAA) begin n_fail++; $display("FAIL alt_hold: got vld=%b out=%h want 0/aaaa", word_valid, parallel_out); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    int first, last, pulses;
    first = -1; last = -1; pulses = 0;
    for (int n = 0; n < 32; n++) begin
      w = (n < 16) ? 16'h00FF : 16'hF0F0;
      step(1'b1, 1'b1, w[15 - (n % 16)], n == 0);
      if (word_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = n;
        last = n;
      end
      if (n == 15) begin
        n_cmp++; if (word_valid !== 1'b1 || parallel_out !== 16'h00FF || toggle_count !== 5'd1 || alt_detect !== 1'b0) begin n_fail++; $display("FAIL b2b_word0: got vld=%b out=%h tc=%0d alt=%b want 1/00ff/1/0", word_valid, parallel_out, toggle_count, alt_detect); end
      end
      if (n == 31) begin
        n_cmp++; if (word_valid !== 1'b1 || parallel_out !== 16'hF0F0 || toggle_count !== 5'd3 || alt_detect !== 1'b0) begin n_fail++; $display("FAIL b2b_word1: got vld=%b out=%h tc=%0d alt=%b want 1/f0f0/3/0", word_valid, parallel_out, toggle_count, alt_detect); end
      end
    end
    n_cmp++; if (pulses != 2 || last - first != 16) begin n_fail++; $display("FAIL b2b_spacing: got pulses=%0d gap=%0d want 2/16", pulses, last - first); end
  endtask

  task automatic test_resync();
    logic [15:0] w;
    int pulses;
    w = 16'h1234; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'($urandom), i == 0);
      if (word_valid === 1'b1) pulses++;
    end
    for (int n = 0; n < 16; n++) begin
      step(1'b1, 1'b1, w[15 - n], n == 0);
      if (n == 0) begin
        n_cmp++; if (bit_count !== 4'd1) begin n_fail++; $display("FAIL resync_bit_count: got %0d want 1", bit_count); end
      end
      if (n < 15 && word_valid === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL resync_partial_pulse: got %0d pulses want 0", pulses); end
    n_cmp++; if (word_valid !== 1'b1 || parallel_out !== 16'h1234) begin n_fail++; $display("FAIL resync_word: got vld=%b out=%h want 1/1234", word_valid, parallel_out); end
    n_cmp++; if (toggle_count !== m_tc) begin n_fail++; $display("FAIL resync_toggle_count: got %0d want %0d", toggle_count, m_tc); end
  endtask

  task automatic test_gaps();
    int pulses;
    pulses = 0;
    for (int n = 0; n < 16; n++) begin
      step(1'b1, 1'b1, 1'b1, n == 0);
      if (word_valid === 1'b1) pulses++;
      if (n < 15) begin
        for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
          step(1'b1, 1'b0, 1'($urandom), 1'b0);
          if (word_valid === 1'b1) pulses++;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'($urandom), 1'b0);
      if (word_valid === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL gaps_pulses: got %0d want 1", pulses); end
    n_cmp++; if (parallel_out !== 16'hFFFF || toggle_count !== 5'd0 || alt_detect !== 1'b0) begin n_fail++; $display("FAIL gaps_word: got out=%h tc=%0d alt=%b want ffff/0/0", parallel_out, toggle_count, alt_detect); end
  endtask

  task automatic test_reset_mid_word();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'($urandom), i == 0);
    step(1'b0, 1'b1, 1'($urandom), 1'($urandom));
    n_cmp++; if (parallel_out !== 16'h0 || word_valid !== 1'b0 || bit_count !== 4'd0 || toggle_count !== 5'd0 || alt_detect !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got out=%h vld=%b cnt=%0d tc=%0d alt=%b want all 0", parallel_out, word_valid, bit_count, toggle_count, alt_detect);
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b1, 1'($urandom), 1'b0);
      if (word_valid === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL midreset_no_pulse: got %0d pulses want 0", pulses); end
    for (int n = 0; n < 16; n++) step(1'b1, 1'b1, 1'($urandom), n == 0);
    n_cmp++; if (word_valid !== 1'b1 || parallel_out !== m_out) begin n_fail++; $display("FAIL midreset_new_word: got vld=%b out=%h want 1/%h", word_valid, parallel_out, m_out); end
  endtask

  task automatic test_sync_on_16th();
    for (int n = 0; n < 15; n++) step(1'b1, 1'b1, 1'($urandom), n == 0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (word_valid !== 1'b0 || bit_count !== 4'd1) begin n_fail++; $display("FAIL sync16_priority: got vld=%b cnt=%0d want 0/1", word_valid, bit_count); end
    for (int n = 0; n < 15; n++) step(1'b1, 1'b1, 1'($urandom), 1'b0);
    n_cmp++; if (word_valid !== 1'b1 || parallel_out !== m_out || parallel_out[15] !== 1'b1) begin n_fail++; $display("FAIL sync16_restart_word: got vld=%b out=%h want 1/%h", word_valid, parallel_out, m_out); end
  endtask

  task automatic test_loopback();
    logic [15:0] circ;
    logic b;
    int pulses, bad;
    circ = 16'hAAAA; pulses = 0; bad = 0;
    for (int n = 0; n < 64; n++) begin
      b = circ[15];
      circ = {circ[14:0], circ[15]};
      step(1'b1, 1'b1, b, n == 0);
      if (word_valid === 1'b1) begin
        pulses++;
        if (parallel_out !== 16'hAAAA && parallel_out !== 16'h5555) bad++;
      end
      if (pulses > 0 && alt_detect !== 1'b1) bad++;
    end
    n_cmp++; if (pulses != 4) begin n_fail++; $display("FAIL loopback_pulses: got %0d want 4", pulses); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL loopback_pattern: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 150) != 0, ($urandom % 4) != 0, 1'($urandom), ($urandom % 45) == 0);
      n_cmp++;
      if (word_valid !== m_vld || parallel_out !== m_out || bit_count !== 4'(q.size()) ||
          toggle_count !== m_tc || alt_detect !== m_alt) begin
        n_fail++;
        if (bad++ < 10)
          $display("FAIL random_cycle%0d: got vld=%b out=%h cnt=%0d tc=%0d alt=%b want %b/%h/%0d/%0d/%b",
                   i, word_valid, parallel_out, bit_count, toggle_count, alt_detect,
                   m_vld, m_out, q.size(), m_tc, m_alt);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; shift_en = 1'b0; shift_in = 1'b0; sync = 1'b0;
    m_act = 0; m_out = '0; m_tc = '0; m_alt = 0; m_vld = 0;
    test_reset();
    test_alternating();
    test_back_to_back();
    test_resync();
    test_gaps();
    test_reset_mid_word();
    test_sync_on_16th();
    test_loopback();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_capture_reg_16bits.md
SERIAL_CAPTURE_REG_16BITS -- requirements
Module: serial_capture_reg_16bits

Interface
REQ-001 Parameter: WIDTH, 16, number of bits per captured word; the only supported value is 16.
REQ-002 Port: clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 Port: shift_in  input  1  serial data bit, sampled only when shift_en=1.
REQ-005 Port: shift_en  input  1  bit-valid qualifier; one bit is consumed per cycle while it is high.
REQ-006 Port: sync  input  1  frame-alignment strobe; marks the current or next bit as bit 0 of a new word.
REQ-007 Port: parallel_out  output  16  last completed word; the first received bit is at [15] (MSB-first).
REQ-008 Port: word_valid  output  1  one-cycle pulse when parallel_out is updated.
REQ-009 Port: bit_count  output  4  number of bits collected in the current partial word (0..15).
REQ-010 Port: toggle_count  output  5  number of adjacent-bit transitions in the last completed word (0..15).
REQ-011 Port: alt_detect  output  1  high while the last completed word is 16'hAAAA or 16'h5555 (clock/2 pattern).

Function
REQ-012 The FSM SHALL have two states: IDLE and COLLECT.
REQ-013 In IDLE, the block SHALL ignore shift_en unless sync=1.
REQ-014 sync=1 with shift_en=1 SHALL capture shift_in as bit 0, set bit_count=1, and enter COLLECT.
REQ-015 sync=1 with shift_en=0 SHALL set bit_count=0 and enter COLLECT.
REQ-016 In COLLECT, each shift_en=1 cycle SHALL shift shift_in into the LSB of an internal 16-bit shift register and increment bit_count.
REQ-017 Capture of the 16th bit SHALL cause the following in the next cycle: parallel_out is loaded, toggle_count and alt_detect are updated, word_valid=1 for exactly one cycle, and bit_count=0.
REQ-018 After a word completes, the block SHALL remain in COLLECT and frame continuously; there is no gap cycle, so back-to-back shift_en yields one word every 16 cycles.
REQ-019 sync=1 in COLLECT mid-word SHALL discard the partial word without producing word_valid; the restart follows REQ-014 and REQ-015.
REQ-020 sync coincident with the 16th bit SHALL take priority: the partial word is discarded, no word_valid is produced, and framing restarts.
REQ-021 shift_en=0 cycles SHALL hold all state; gaps of any length are allowed inside a word.
REQ-022 parallel_out, toggle_count and alt_detect SHALL hold their values between words.
REQ-023 toggle_count SHALL equal the count of i in 0..14 where word[i] differs from word[i+1]; the result is 5 bits wide and never wraps.

Reset
REQ-024 When reset_n=0 at a clock edge, the block SHALL apply all of the following regardless of other inputs: state=IDLE, shift register=0, parallel_out=16'h0000, bit_count=0, toggle_count=0, alt_detect=0, word_valid=0.
REQ-025 A reset mid-word SHALL discard the partial word, and no word_valid SHALL follow the reset.

Structure
REQ-026 The FSM state encoding (IDLE, COLLECT), WIDTH and the constants 16'hAAAA and 16'h5555 SHALL live in a shared package.
REQ-027 The transition counter SHALL be a combinational sub-module named transition_counter_16bits, instantiated once.

Verification
REQ-028 Scenario: reset, then sync with shift_en=1 and bits 1,0,1,0,... for 16 cycles -> parallel_out=16'hAAAA, toggle_count=15, alt_detect=1, and word_valid is high 1 cycle after the 16th bit.
REQ-029 Scenario: 32 continuous bits 16'h00FF then 16'hF0F0 -> two word_valid pulses 16 cycles apart; toggle_count is 1 and then 3; alt_detect=0.
REQ-030 Scenario: 5 bits, then sync with the bit pattern of 16'h1234 -> no pulse for the partial word; parallel_out=16'h1234, and bit_count reads 1 on the cycle after sync.
REQ-031 Scenario: 16'hFFFF delivered with shift_en=0 gaps of 1-3 cycles between bits -> parallel_out=16'hFFFF, toggle_count=0, and exactly one word_valid.
REQ-032 Scenario: reset_n=0 after 9 bits -> all outputs are 0 the next cycle, and no word_valid occurs until a new sync plus 16 bits.
REQ-033 Scenario: loopback from circ_shift_reg_16bits (load 16'hAAAA, then shift every cycle, sync on the first shift cycle) -> parallel_out is 16'hAAAA or 16'h5555 every 16 cycles, with alt_detect=1 throughout.
